// File: rtl/sa_cache_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sa_cache_mem_ctrl
//  Description : Memory-side controller for sa_cache. It serves line refills,
//                buffers victim evictions in a small FIFO, forwards refills
//                that hit a buffered victim, and shares a single req/ack
//                memory port. Reads take priority over write-buffer drains.
//  Revision    : 1.0 - initial release
// ============================================================================
module sa_cache_mem_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_miss_valid,
    input  logic [ADDR_W-1:0]           i_miss_addr,
    output logic                        o_miss_ready,
    input  logic                        i_evict_valid,
    input  logic [ADDR_W-1:0]           i_evict_addr,
    input  logic [DATA_W-1:0]           i_evict_data,
    output logic                        o_evict_ready,
    output logic [DATA_W-1:0]           o_memory_line,
    output logic                        o_memory_response,
    output logic                        o_mem_req,
    output logic                        o_mem_we,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic [DATA_W-1:0]           o_mem_wdata,
    input  logic                        i_mem_ack,
    input  logic [DATA_W-1:0]           i_mem_rdata,
    output logic [$clog2(WB_DEPTH):0]   o_wb_count
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(WB_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;

    // Write buffer storage and bookkeeping
    logic [ADDR_W-1:0]   r_wb_addr [WB_DEPTH];
    logic [DATA_W-1:0]   r_wb_data [WB_DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;

    // Memory port and response registers
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_line;

    logic                w_push;
    logic                w_pop;
    logic                w_miss_acc;
    logic                w_hit;
    logic [DATA_W-1:0]   w_hit_data;
    logic [PTR_W-1:0]    w_idx;

    // Slot availability comes from the registered count only, so a pop in
    // the same cycle never opens a slot for an incoming victim.
    assign o_evict_ready     = (r_count != c_full);
    assign o_miss_ready      = (r_state == IDLE);
    assign w_push            = i_evict_valid && o_evict_ready;
    assign w_pop             = (r_state == WRITE) && i_mem_ack;
    assign w_miss_acc        = i_miss_valid && (r_state == IDLE);

    assign o_memory_response = (r_state == RESP);
    assign o_memory_line     = r_line;
    assign o_mem_req         = r_mem_req;
    assign o_mem_we          = r_mem_we;
    assign o_mem_addr        = r_mem_addr;
    assign o_mem_wdata       = r_mem_wdata;
    assign o_wb_count        = r_count;

    // Forwarding search: walk entries oldest to newest so the newest match
    // overwrites older ones; a victim arriving this cycle is newer still.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        w_idx      = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_wb_addr[w_idx] == i_miss_addr)) begin
                w_hit      = 1'b1;
                w_hit_data = r_wb_data[w_idx];
            end
        end
        if (w_push && (i_evict_addr == i_miss_addr)) begin
            w_hit      = 1'b1;
            w_hit_data = i_evict_data;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic: misses beat drains, transfers complete on ack
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (w_miss_acc) begin
                    w_state_nx = w_hit ? RESP : READ;
                end else if (r_count != '0) begin
                    w_state_nx = WRITE;
                end
            end
            READ:    if (i_mem_ack) w_state_nx = RESP;
            WRITE:   if (i_mem_ack) w_state_nx = IDLE;
            RESP:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Memory port request and refill line capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_line      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss_acc) begin
                        if (w_hit) begin
                            r_line <= w_hit_data;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= i_miss_addr;
                        end
                    end else if (r_count != '0) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_wb_addr[r_head];
                        r_mem_wdata <= r_wb_data[r_head];
                    end
                end
                READ: begin
                    if (i_mem_ack) begin
                        r_line    <= i_mem_rdata;
                        r_mem_req <= 1'b0;
                    end
                end
                WRITE: begin
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write-buffer pointers and occupancy; reset discards buffered victims
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Write-buffer payload; validity is tracked by the pointers alone
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wb_addr[r_tail] <= i_evict_addr;
            r_wb_data[r_tail] <= i_evict_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sa_cache_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sa_cache_mem_ctrl
//  Description : Directed self-checking bench for sa_cache_mem_ctrl. Inputs
//                change and outputs are checked on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_cache_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        miss_ready;
    logic        evict_valid;
    logic [31:0] evict_addr;
    logic [31:0] evict_data;
    logic        evict_ready;
    logic [31:0] memory_line;
    logic        memory_response;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [2:0]  wb_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    sa_cache_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .WB_DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_miss_valid      (miss_valid),
        .i_miss_addr       (miss_addr),
        .o_miss_ready      (miss_ready),
        .i_evict_valid     (evict_valid),
        .i_evict_addr      (evict_addr),
        .i_evict_data      (evict_data),
        .o_evict_ready     (evict_ready),
        .o_memory_line     (memory_line),
        .o_memory_response (memory_response),
        .o_mem_req         (mem_req),
        .o_mem_we          (mem_we),
        .o_mem_addr        (mem_addr),
        .o_mem_wdata       (mem_wdata),
        .i_mem_ack         (mem_ack),
        .i_mem_rdata       (mem_rdata),
        .o_wb_count        (wb_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; miss_valid = 1'b0; miss_addr = '0;
        evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();

        // Reset values
        chk("rst_miss_ready",  {31'd0, miss_ready}, 32'd1);
        chk("rst_evict_ready", {31'd0, evict_ready}, 32'd1);
        chk("rst_req",         {31'd0, mem_req}, 32'd0);
        chk("rst_we",          {31'd0, mem_we}, 32'd0);
        chk("rst_addr",        mem_addr, 32'd0);
        chk("rst_wdata",       mem_wdata, 32'd0);
        chk("rst_line",        memory_line, 32'd0);
        chk("rst_resp",        {31'd0, memory_response}, 32'd0);
        chk("rst_count",       {29'd0, wb_count}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: plain refill with a 3-cycle memory latency
        miss_valid = 1'b1; miss_addr = 32'h100;
        chk("t1_ready_idle", {31'd0, miss_ready}, 32'd1);
        tick();
        miss_valid = 1'b0;
        chk("t1_req",        {31'd0, mem_req}, 32'd1);
        chk("t1_we",         {31'd0, mem_we}, 32'd0);
        chk("t1_addr",       mem_addr, 32'h100);
        chk("t1_ready_busy", {31'd0, miss_ready}, 32'd0);
        tick();
        chk("t1_req_hold1",  {31'd0, mem_req}, 32'd1);
        tick();
        chk("t1_req_hold2",  {31'd0, mem_req}, 32'd1);
        chk("t1_we_hold",    {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        chk("t1_resp",       {31'd0, memory_response}, 32'd1);
        chk("t1_line",       memory_line, 32'hDEADBEEF);
        chk("t1_req_drop",   {31'd0, mem_req}, 32'd0);
        chk("t1_we_resp",    {31'd0, mem_we}, 32'd0);
        tick();
        chk("t1_resp_pulse", {31'd0, memory_response}, 32'd0);
        chk("t1_ready_back", {31'd0, miss_ready}, 32'd1);

        // 2: refill forwarded from a buffered victim, victim drained later
        evict_valid = 1'b1; evict_addr = 32'h40; evict_data = 32'h11112222;
        tick();
        evict_valid = 1'b0;
        miss_valid = 1'b1; miss_addr = 32'h40;
        chk("t2_count1",     {29'd0, wb_count}, 32'd1);
        tick();
        miss_valid = 1'b0;
        chk("t2_resp",       {31'd0, memory_response}, 32'd1);
        chk("t2_line",       memory_line, 32'h11112222);
        chk("t2_no_req",     {31'd0, mem_req}, 32'd0);
        tick();
        chk("t2_no_req2",    {31'd0, mem_req}, 32'd0);
        chk("t2_resp_off",   {31'd0, memory_response}, 32'd0);
        tick();
        chk("t2_wr_req",     {31'd0, mem_req}, 32'd1);
        chk("t2_wr_we",      {31'd0, mem_we}, 32'd1);
        chk("t2_wr_addr",    mem_addr, 32'h40);
        chk("t2_wr_data",    mem_wdata, 32'h11112222);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t2_count0",     {29'd0, wb_count}, 32'd0);
        chk("t2_req_drop",   {31'd0, mem_req}, 32'd0);

        // 3: fill the buffer, back-pressure, then FIFO drain order
        for (int k = 0; k < 4; k++) begin
            evict_valid = 1'b1;
            evict_addr  = 32'h1000 + k;
            evict_data  = 32'hCAFE0000 + k;
            tick();
        end
        evict_addr = 32'h1004; evict_data = 32'hCAFE0004;
        chk("t3_full_count", {29'd0, wb_count}, 32'd4);
        chk("t3_full_ready", {31'd0, evict_ready}, 32'd0);
        chk("t3_head_req",   {31'd0, mem_req}, 32'd1);
        chk("t3_head_addr",  mem_addr, 32'h1000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t3_pop_count",  {29'd0, wb_count}, 32'd3);
        chk("t3_pop_ready",  {31'd0, evict_ready}, 32'd1);
        tick();
        evict_valid = 1'b0;
        chk("t3_refill_cnt", {29'd0, wb_count}, 32'd4);
        for (int k = 1; k <= 4; k++) begin
            chk("t3_drain_req",  {31'd0, mem_req}, 32'd1);
            chk("t3_drain_we",   {31'd0, mem_we}, 32'd1);
            chk("t3_drain_addr", mem_addr, 32'h1000 + k);
            chk("t3_drain_data", mem_wdata, 32'hCAFE0000 + k);
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            tick();
        end
        chk("t3_empty",      {29'd0, wb_count}, 32'd0);
        chk("t3_idle_req",   {31'd0, mem_req}, 32'd0);

        // 4: a pending miss is served before buffered writes
        miss_valid = 1'b1; miss_addr = 32'h300;
        evict_valid = 1'b1; evict_addr = 32'h500; evict_data = 32'h55555555;
        tick();
        miss_valid = 1'b0;
        evict_addr = 32'h600; evict_data = 32'h66666666;
        chk("t4_rd1_req",    {31'd0, mem_req}, 32'd1);
        chk("t4_rd1_we",     {31'd0, mem_we}, 32'd0);
        chk("t4_rd1_addr",   mem_addr, 32'h300);
        tick();
        evict_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h33333333;
        chk("t4_count2",     {29'd0, wb_count}, 32'd2);
        tick();
        mem_ack = 1'b0;
        miss_valid = 1'b1; miss_addr = 32'h200;
        chk("t4_rd1_resp",   {31'd0, memory_response}, 32'd1);
        chk("t4_rd1_line",   memory_line, 32'h33333333);
        tick();
        chk("t4_idle_ready", {31'd0, miss_ready}, 32'd1);
        tick();
        miss_valid = 1'b0;
        chk("t4_rd2_req",    {31'd0, mem_req}, 32'd1);
        chk("t4_rd2_we",     {31'd0, mem_we}, 32'd0);
        chk("t4_rd2_addr",   mem_addr, 32'h200);
        mem_ack = 1'b1; mem_rdata = 32'h22222222;
        tick();
        mem_ack = 1'b0;
        chk("t4_rd2_resp",   {31'd0, memory_response}, 32'd1);
        chk("t4_rd2_line",   memory_line, 32'h22222222);
        chk("t4_cnt_kept",   {29'd0, wb_count}, 32'd2);
        tick();
        tick();
        chk("t4_wr1_we",     {31'd0, mem_we}, 32'd1);
        chk("t4_wr1_addr",   mem_addr, 32'h500);
        chk("t4_wr1_data",   mem_wdata, 32'h55555555);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("t4_wr2_we",     {31'd0, mem_we}, 32'd1);
        chk("t4_wr2_addr",   mem_addr, 32'h600);
        chk("t4_wr2_data",   mem_wdata, 32'h66666666);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t4_empty",      {29'd0, wb_count}, 32'd0);
        tick();

        // 5: miss hits a victim offered in the same cycle
        evict_valid = 1'b1; evict_addr = 32'h80; evict_data = 32'hA5A5A5A5;
        miss_valid = 1'b1; miss_addr = 32'h80;
        tick();
        evict_valid = 1'b0; miss_valid = 1'b0;
        chk("t5_resp",       {31'd0, memory_response}, 32'd1);
        chk("t5_line",       memory_line, 32'hA5A5A5A5);
        chk("t5_count",      {29'd0, wb_count}, 32'd1);
        chk("t5_no_req",     {31'd0, mem_req}, 32'd0);
        tick();
        tick();
        chk("t5_wr_addr",    mem_addr, 32'h80);
        chk("t5_wr_data",    mem_wdata, 32'hA5A5A5A5);
        chk("t5_wr_we",      {31'd0, mem_we}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();

        // 6: reset during a read abandons it and empties the buffer
        miss_valid = 1'b1; miss_addr = 32'h700;
        tick();
        miss_valid = 1'b0;
        evict_valid = 1'b1; evict_addr = 32'h900; evict_data = 32'h99999999;
        chk("t6_req",        {31'd0, mem_req}, 32'd1);
        tick();
        evict_valid = 1'b0;
        rst = 1'b1;
        chk("t6_count_pre",  {29'd0, wb_count}, 32'd1);
        tick();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        chk("t6_req_drop",   {31'd0, mem_req}, 32'd0);
        chk("t6_count0",     {29'd0, wb_count}, 32'd0);
        chk("t6_miss_ready", {31'd0, miss_ready}, 32'd1);
        tick();
        mem_ack = 1'b0;
        chk("t6_no_resp",    {31'd0, memory_response}, 32'd0);
        chk("t6_line",       memory_line, 32'd0);
        chk("t6_no_req",     {31'd0, mem_req}, 32'd0);
        tick();
        chk("t6_no_resp2",   {31'd0, memory_response}, 32'd0);
        chk("t6_no_req2",    {31'd0, mem_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
